pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline stage register. It is the successor to the fixed-field stage latches that sit between fetch/decode/execute/memory/writeback.
- Carries a packed payload of WIDTH bits with a valid bit.
- Provides a valid/ready handshake with a one-entry skid buffer, so that in_ready is a registered signal.
- Supports a global stall hold, flush-to-bubble (payload forced to a NOP encoding) and a saturating stall-cycle performance counter.

Parameters:
- WIDTH, 32: payload width in bits.
- NOP_VALUE, {WIDTH{1'b0}}: payload driven and stored whenever a slot is empty (bubble encoding).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  one clock; reset is synchronous and active-high.
- in_valid  in  1  upstream presents payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- out_valid  out  1  main slot holds a live entry.
- out_data  out  WIDTH  main slot payload; NOP_VALUE when !out_valid.
- out_ready  in  1  downstream can accept.
- stall  in  1  hazard-unit hold; blocks output consumption.
- flush  in  1  squash all held entries (branch mispredict, exception).
- stall_cnt  out  CNT_W  saturating count of blocked cycles.

Behaviour:
- State:
  - main slot: main_valid, main_data.
  - skid slot: skid_valid, skid_data.
  - stall_cnt.
- Reset (sync, when reset=1 at posedge):
  - main_valid=0, skid_valid=0.
  - main_data=skid_data=NOP_VALUE.
  - stall_cnt=0.
  - Consequently in_ready=1, out_valid=0, out_data=NOP_VALUE after the edge.
  - Reset overrides flush, stall and all handshakes.
- Definitions:
  - take = out_valid & out_ready & !stall.
  - acc = in_valid & in_ready.
- Flush (reset=0, flush=1): at the edge, both slots are cleared to invalid/NOP_VALUE and any acc that cycle is discarded. Flush has priority over stall and acc. stall_cnt is unaffected.
- Normal update (no reset, no flush):
  - main empty or take, and skid_valid: skid moves to main; skid takes in_data if acc, else becomes empty/NOP.
  - main empty or take, and !skid_valid: main takes in_data if acc, else becomes empty/NOP.
  - main full and !take: acc writes the skid slot. acc is only possible when skid is empty, so there is no overwrite.
- Ordering: FIFO; entries leave in arrival order, with no loss or duplication.
- Latency and throughput:
  - 1 cycle from acc to out_valid when the stage is empty.
  - Full throughput of 1 entry/cycle with steady out_ready=1 and stall=0.
- in_ready deasserts the cycle after the skid fills; it reasserts the cycle after the skid drains.
- Counter:
  - stall_cnt increments when out_valid & !take & !flush; it holds otherwise.
  - It saturates at all-ones and does not wrap.
- Simultaneous take and acc with a full skid cannot occur, because in_ready=0 then.
- stall=1 with out_ready=1: no consumption; the counter increments.
- A combinational path from out_ready/stall to in_ready is forbidden.

Decomposition:
- Shared package pipe_pkg:
  - default NOP encoding constant (shared with decode).
  - CNT_W default.
  - payload-width localparams for each stage boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W).
- Per-stage field structs are packed and unpacked by the instantiating stage, not inside this block.
- Optional sub-module sat_counter (CNT_W, increment enable, sync reset) for stall_cnt; all other logic is flat.

Test Plan:
- Reset, then idle: assert reset 2 cycles with in_valid=1, in_data=32'hDEADBEEF. Required: out_valid=0, out_data=0, in_ready=1, stall_cnt=0; nothing is captured.
- Streaming: out_ready=1, stall=0; push 8 words 1..8 on back-to-back cycles. Required: out_data = 1..8 on consecutive cycles, one cycle after each push; in_ready stays 1.
- Backpressure/skid: after pushing 0xA, raise stall for 3 cycles while pushing 0xB, 0xC. Required:
  - 0xB lands in the skid and in_ready drops next cycle.
  - 0xC is held upstream.
  - stall_cnt=3.
  - After release the output order is A, B, C with no loss.
- Flush with both slots full: main=0x11, skid=0x22, in_valid=1 with 0x33, flush=1. Required next cycle: out_valid=0, out_data=NOP_VALUE, in_ready=1; 0x33 is dropped; stall_cnt is unchanged.
- Counter saturation: CNT_W=4, hold stall with a valid entry for 20 cycles. Required: stall_cnt reaches 4'hF and stays there.
- Reset mid-operation: both slots full and stall=1, assert reset for 1 cycle. Required: all outputs at reset values next cycle; a push the following cycle appears after 1 cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: bubble encoding, counter width
// and payload widths at each stage boundary.
package pipe_pkg;

  localparam int XLEN = 32;

  // Bubble payload; decode treats an all-zero word as a NOP slot.
  localparam logic [XLEN-1:0] NOP_ENC = '0;

  localparam int CNT_W_DEF = 16;

  localparam int IF_ID_W  = 2 * XLEN;
  localparam int ID_EX_W  = 4 * XLEN + 16;
  localparam int EX_MEM_W = 3 * XLEN + 8;
  localparam int MEM_WB_W = 2 * XLEN + 8;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous
// active-high reset.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic sat;

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a one-entry
// skid buffer, flush-to-bubble and a stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic             take;
  logic             acc;
  logic             mainFree;
  logic [WIDTH-1:0] accData;
  logic             cntInc;

  assign take     = mainValid & out_ready & ~stall;
  // in_ready is the skid flag itself, so no path from out_ready/stall.
  assign acc      = in_valid & ~skidValid;
  assign mainFree = ~mainValid | take;
  assign accData  = acc ? in_data : NOP_VALUE;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mainValid <= 1'b0;
      mainData  <= NOP_VALUE;
      skidValid <= 1'b0;
      skidData  <= NOP_VALUE;
    end else if (mainFree) begin
      if (skidValid) begin
        mainValid <= 1'b1;
        mainData  <= skidData;
        skidValid <= acc;
        skidData  <= accData;
      end else begin
        mainValid <= acc;
        mainData  <= accData;
      end
    end else if (acc) begin
      skidValid <= 1'b1;
      skidData  <= in_data;
    end
  end

  assign in_ready  = ~skidValid;
  assign out_valid = mainValid;
  assign out_data  = mainData;

  assign cntInc = mainValid & ~take & ~flush;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stallCnt (
    .clk  (clk),
    .reset(reset),
    .inc  (cntInc),
    .cnt  (stall_cnt)
  );

endmodule
